multicycle_controller: RTL and testbench

Control unit for the multicycle RV32I datapath variant: a Moore state machine that sequences every instruction through fetch, decode, execute, memory and writeback steps. It drives the shared ALU, memory-address mux, instruction register and register-file write port, and it reuses the ALU for PC+4 and branch-target arithmetic. It replaces the single-cycle main/ALU decoders. The top level instantiates it beside the datapath; the processor bench observes its `state` output.

---
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle RV32I datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives the shared ALU and muxes.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } statetype;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       adrsrc;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctltype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  statetype cur, nxt;
  ctltype   ctl;

  // Control word for a given state; registering it alongside the state keeps the
  // outputs glitch-free and aligned with the state they belong to.
  function automatic ctltype decode(input statetype s);
    ctltype c;
    c = '0;
    case (s)
      FETCH:    begin c.irwrite = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.pcupdate = 1'b1; end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      EXECUTER: begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      EXECUTEI: begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      ALUWB:    c.regwrite = 1'b1;
      JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:                   nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:                  nxt = MEMWB;
      EXECUTER, EXECUTEI, JAL:  nxt = ALUWB;
      default:                  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
      ctl <= decode(FETCH);
    end else begin
      cur <= nxt;
      ctl <= decode(nxt);
    end
  end

  // Enables are gated by reset directly so nothing is written while reset is held.
  assign PCWrite   = ~reset & (ctl.pcupdate | (ctl.branch & Zero));
  assign IRWrite   = ~reset & ctl.irwrite;
  assign RegWrite  = ~reset & ctl.regwrite;
  assign MemWrite  = ~reset & ctl.memwrite;
  assign AdrSrc    = ctl.adrsrc;
  assign ResultSrc = ctl.resultsrc;
  assign ALUSrcA   = ctl.alusrca;
  assign ALUSrcB   = ctl.alusrcb;
  assign state     = cur;

  always_comb begin
    ALUControl = 3'b000;
    case (ctl.aluop)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: random instruction stream with random resets,
// checked each cycle against an instruction-level model, plus a few literal checks.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
  } instr_t;

  instr_t fq[$];
  instr_t cur_i;
  int     q[$];
  bit     prev_reset = 1'b1;
  bit     chk = 1'b0;
  bit     force_zero = 1'b0;
  bit     zero_val = 1'b0;
  int     n_checks = 0;
  int     n_fail = 0;

  int e_state, e_pcwrite, e_adrsrc, e_memwrite, e_irwrite, e_regwrite;
  int e_resultsrc, e_srca, e_srcb, e_alu, e_imm;

  // Steps each instruction class walks through, from FETCH onward.
  function automatic void build_seq(input logic [6:0] o);
    case (o)
      LW:      q = '{0, 1, 2, 3, 4};
      SW:      q = '{0, 1, 2, 5};
      RT:      q = '{0, 1, 6, 7};
      IT:      q = '{0, 1, 8, 7};
      JL:      q = '{0, 1, 9, 7};
      BQ:      q = '{0, 1, 10};
      default: q = '{0, 1};
    endcase
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    logic [6:0] bad[5];
    bad = '{7'b0000000, 7'b0110111, 7'b0010111, 7'b1100111, 7'b1111111};
    case ($urandom_range(0, 6))
      0:       r.op = LW;
      1:       r.op = SW;
      2:       r.op = RT;
      3:       r.op = IT;
      4:       r.op = JL;
      5:       r.op = BQ;
      default: r.op = bad[$urandom_range(0, 4)];
    endcase
    r.f3 = 3'($urandom_range(0, 7));
    r.f7 = 1'($urandom_range(0, 1));
    return r;
  endfunction

  // ALU operation the instruction semantics call for: 0 add, 1 sub, 2 and, 3 or, 5 slt.
  function automatic int alu_for(input int s, input instr_t i);
    if (s == 6 || s == 8) begin
      case (i.f3)
        3'd0:    return (s == 6 && i.f7) ? 1 : 0;
        3'd2:    return 5;
        3'd6:    return 3;
        3'd7:    return 2;
        default: return 0;
      endcase
    end
    if (s == 10) return 1;
    return 0;
  endfunction

  function automatic int imm_for(input logic [6:0] o);
    case (o)
      SW:      return 1;
      BQ:      return 2;
      JL:      return 3;
      default: return 0;
    endcase
  endfunction

  task automatic set_expect(input bit rst);
    int pc_adv;
    pc_adv = 0;
    e_adrsrc = 0; e_irwrite = 0; e_regwrite = 0; e_memwrite = 0;
    e_resultsrc = 0; e_srca = 0; e_srcb = 0;
    case (e_state)
      0:  begin e_irwrite = 1; e_srcb = 2; e_resultsrc = 2; pc_adv = 1; end
      1:  begin e_srca = 1; e_srcb = 1; end
      2:  begin e_srca = 2; e_srcb = 1; end
      3:  e_adrsrc = 1;
      4:  begin e_resultsrc = 1; e_regwrite = 1; end
      5:  begin e_adrsrc = 1; e_memwrite = 1; end
      6:  e_srca = 2;
      7:  e_regwrite = 1;
      8:  begin e_srca = 2; e_srcb = 1; end
      9:  begin e_srca = 1; e_srcb = 2; pc_adv = 1; end
      10: begin e_srca = 2; pc_adv = zero ? 1 : 0; end
      default: ;
    endcase
    e_pcwrite = (!rst && pc_adv != 0) ? 1 : 0;
    if (rst) begin
      e_irwrite = 0; e_regwrite = 0; e_memwrite = 0;
    end
    e_alu = alu_for(e_state, cur_i);
    e_imm = imm_for(cur_i.op);
  endtask

  task automatic applyStimulus(input bit rst);
    if (prev_reset) q.delete();
    if (q.size() == 0) begin
      if (fq.size() > 0) cur_i = fq.pop_front();
      else cur_i = rand_instr();
      build_seq(cur_i.op);
    end
    e_state  = q.pop_front();
    reset    = rst;
    op       = cur_i.op;
    funct3   = cur_i.f3;
    funct7b5 = cur_i.f7;
    zero     = force_zero ? zero_val : 1'($urandom_range(0, 1));
    if (rst) q.delete();
    prev_reset = rst;
    set_expect(rst);
    chk = 1'b1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h (state model %0d)", name, $time, act, exp, e_state);
    end
  endtask

  task automatic checkOutput();
    cmp("state",      32'(state),      32'(e_state));
    cmp("PCWrite",    32'(PCWrite),    32'(e_pcwrite));
    cmp("AdrSrc",     32'(AdrSrc),     32'(e_adrsrc));
    cmp("MemWrite",   32'(MemWrite),   32'(e_memwrite));
    cmp("IRWrite",    32'(IRWrite),    32'(e_irwrite));
    cmp("RegWrite",   32'(RegWrite),   32'(e_regwrite));
    cmp("ResultSrc",  32'(ResultSrc),  32'(e_resultsrc));
    cmp("ALUSrcA",    32'(ALUSrcA),    32'(e_srca));
    cmp("ALUSrcB",    32'(ALUSrcB),    32'(e_srcb));
    cmp("ALUControl", 32'(ALUControl), 32'(e_alu));
    cmp("ImmSrc",     32'(ImmSrc),     32'(e_imm));
  endtask

  always @(negedge clk) begin
    if (chk) checkOutput();
  end

  task automatic runCycle(input bit rst);
    @(posedge clk);
    #1;
    applyStimulus(rst);
  endtask

  initial begin
    reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (4) fq.push_back('{LW, 3'b010, 1'b0});

    // Reset, release into lw, then reset twice while in DECODE/FETCH
    runCycle(1'b1);
    runCycle(1'b0);
    runCycle(1'b1);
    #3;
    cmp("lit_rst_decode_state", 32'(state), 32'd1);
    cmp("lit_rst_enables", {28'd0, PCWrite, IRWrite, RegWrite, MemWrite}, 32'd0);
    runCycle(1'b1);
    #3;
    cmp("lit_rst_fetch_state", 32'(state), 32'd0);
    cmp("lit_rst_fetch_en", {30'd0, PCWrite, IRWrite}, 32'd0);
    runCycle(1'b0);
    #3;
    cmp("lit_release_state", 32'(state), 32'd0);
    cmp("lit_release_en", {30'd0, PCWrite, IRWrite}, 32'd3);
    repeat (4) runCycle(1'b0);
    #3;
    cmp("lit_lw_memwb", {26'd0, state, RegWrite, ResultSrc}, {26'd0, 4'd4, 1'b1, 2'b01});

    fq.push_back('{SW, 3'b010, 1'b0});
    repeat (4) runCycle(1'b0);
    #3;
    cmp("lit_sw_memwrite", {25'd0, state, MemWrite, ImmSrc}, {25'd0, 4'd5, 1'b1, 2'b01});

    fq.push_back('{RT, 3'b000, 1'b1});
    repeat (3) runCycle(1'b0);
    #3;
    cmp("lit_r_sub", {25'd0, state, ALUControl}, {25'd0, 4'd6, 3'b001});
    runCycle(1'b0);

    force_zero = 1'b1; zero_val = 1'b1;
    fq.push_back('{BQ, 3'b000, 1'b0});
    repeat (3) runCycle(1'b0);
    #3;
    cmp("lit_beq_taken", {27'd0, state, PCWrite}, {27'd0, 4'd10, 1'b1});
    force_zero = 1'b0;

    fq.push_back('{7'b0000000, 3'b000, 1'b0});
    runCycle(1'b0);
    #3;
    cmp("lit_after_beq_fetch", 32'(state), 32'd0);
    repeat (2) runCycle(1'b0);
    #3;
    cmp("lit_unsupported_back", 32'(state), 32'd0);

    repeat (3000) runCycle($urandom_range(0, 39) == 0);

    @(posedge clk);
    #1;
    chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
